// File: rtl/bus_xfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl_if
//   Request/strobe bundle between the control unit (master) and the
//   bus transfer sequencer bus_xfer_ctrl (slave).
//
//   Parameters
//     NUM_REGS  number of bus sources/destinations (width of out_en/in_en)
//     SEL_W     width of src_sel/dst_sel
//     CNT_W     width of xfer_count
//
//   Signals (direction as seen by the slave)
//     start       in   transfer request, sampled only while idle
//     src_sel     in   source register index
//     dst_sel     in   destination register index
//     busy        out  sequencer not idle
//     out_en      out  one-hot bus drive enables
//     in_en       out  one-hot register load enables
//     done        out  1-cycle completion pulse
//     err         out  1-cycle reject pulse (index out of range)
//     xfer_count  out  completed-transfer count
// -----------------------------------------------------------------------------
interface bus_xfer_ctrl_if #(
   parameter int NUM_REGS = 32,
   parameter int SEL_W    = 5,
   parameter int CNT_W    = 16
);
   logic                start;
   logic [SEL_W-1:0]    src_sel;
   logic [SEL_W-1:0]    dst_sel;
   logic                busy;
   logic [NUM_REGS-1:0] out_en;
   logic [NUM_REGS-1:0] in_en;
   logic                done;
   logic                err;
   logic [CNT_W-1:0]    xfer_count;

   modport master (
      output start, src_sel, dst_sel,
      input  busy, out_en, in_en, done, err, xfer_count
   );

   modport slave (
      input  start, src_sel, dst_sel,
      output busy, out_en, in_en, done, err, xfer_count
   );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_xfer_ctrl
//   Control-side driver for the shared datapath bus. Accepts a register
//   transfer request (source index, destination index) and sequences the
//   one-hot bus drive strobes (out_en) and register load strobes (in_en):
//     IDLE -> DRIVE (source drives, bus settles)
//          -> LOAD  (source still drives, destination loads)
//          -> DONE  (enables off, done pulse) -> IDLE
//   Requests with an index >= NUM_REGS are rejected with a 1-cycle err pulse.
//   All outputs are registered.
//
//   Ports
//     clock    in   system clock, all state on rising edge
//     clear_n  in   synchronous active-low reset; aborts any transfer
//     bus      slave modport of bus_xfer_ctrl_if (start, src_sel, dst_sel,
//              busy, out_en, in_en, done, err, xfer_count)
//
//   Configuration
//     BUS_XFER_COUNT_EN  when defined, xfer_count counts completed transfers
//                        (saturating, cleared by reset); otherwise it is
//                        tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module bus_xfer_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int SEL_W    = 5,
   parameter int CNT_W    = 16
) (
   input  logic            clock,
   input  logic            clear_n,
   bus_xfer_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One extra bit so NUM_REGS == 2**SEL_W is representable.
   localparam logic [SEL_W:0] NUM_REGS_L = (SEL_W+1)'(NUM_REGS);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    src_q, src_d;
   logic [SEL_W-1:0]    dst_q, dst_d;

   logic                req_ok;
   logic                req_bad;

   logic                busy_d;
   logic [NUM_REGS-1:0] out_en_d;
   logic [NUM_REGS-1:0] in_en_d;
   logic                done_d;
   logic                err_d;

   logic                busy_q;
   logic [NUM_REGS-1:0] out_en_q;
   logic [NUM_REGS-1:0] in_en_q;
   logic                done_q;
   logic                err_q;

   // Request qualification (only meaningful while IDLE)
   always_comb begin
      req_ok  = ({1'b0, bus.src_sel} < NUM_REGS_L) &&
                ({1'b0, bus.dst_sel} < NUM_REGS_L);
      req_bad = bus.start && !req_ok;
   end

   // State register and output register
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         busy_q   <= 1'b0;
         out_en_q <= '0;
         in_en_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         busy_q   <= busy_d;
         out_en_q <= out_en_d;
         in_en_q  <= in_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic; selects are latched only on an accepted request,
   // so select changes while busy have no effect.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start && req_ok) begin
               state_d = DRIVE;
               src_d   = bus.src_sel;
               dst_d   = bus.dst_sel;
            end
         end
         DRIVE:   state_d = LOAD;
         LOAD:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: decoded from the next state so the registered outputs
   // line up with the state they describe.
   always_comb begin
      busy_d   = (state_d != IDLE);
      out_en_d = '0;
      in_en_d  = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_d)
         DRIVE: begin
            out_en_d = NUM_REGS'(1) << src_d;
         end
         LOAD: begin
            out_en_d = NUM_REGS'(1) << src_d;
            in_en_d  = NUM_REGS'(1) << dst_d;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            // A reject can only occur from IDLE, and IDLE is then retained.
            err_d = (state_q == IDLE) && req_bad;
         end
      endcase
   end

   assign bus.busy   = busy_q;
   assign bus.out_en = out_en_q;
   assign bus.in_en  = in_en_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;

`ifdef BUS_XFER_COUNT_EN
   logic [CNT_W-1:0] count_q;

   // Counts in step with the done pulse; saturates at all-ones.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         count_q <= '0;
      end else if ((state_d == DONE) && (count_q != '1)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign bus.xfer_count = count_q;
`else
   assign bus.xfer_count = '0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_xfer_ctrl
//   Directed bench for bus_xfer_ctrl. DUT A (NUM_REGS=32) is driven from a
//   vector table; DUT B (NUM_REGS=24, CNT_W=2) covers out-of-range rejects
//   and the transfer counter with hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

   logic clk = 1'b0;
   logic clear_n;

   always #5 clk = ~clk;

   bus_xfer_ctrl_if #(.NUM_REGS(32), .SEL_W(5), .CNT_W(16)) ifa ();
   bus_xfer_ctrl_if #(.NUM_REGS(24), .SEL_W(5), .CNT_W(2))  ifb ();

   bus_xfer_ctrl #(.NUM_REGS(32), .SEL_W(5), .CNT_W(16)) dut_a (
      .clock   (clk),
      .clear_n (clear_n),
      .bus     (ifa.slave)
   );

   bus_xfer_ctrl #(.NUM_REGS(24), .SEL_W(5), .CNT_W(2)) dut_b (
      .clock   (clk),
      .clear_n (clear_n),
      .bus     (ifb.slave)
   );

   typedef struct {
      string       name;
      logic        rst_n;
      logic        start;
      logic [4:0]  src;
      logic [4:0]  dst;
      logic        exp_busy;
      logic [31:0] exp_out;
      logic [31:0] exp_in;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input string nm, input logic rn, input logic st,
                               input logic [4:0] s, input logic [4:0] d,
                               input logic b, input logic [31:0] o,
                               input logic [31:0] i, input logic dn,
                               input logic er);
      vec_t v;
      v.name = nm; v.rst_n = rn; v.start = st; v.src = s; v.dst = d;
      v.exp_busy = b; v.exp_out = o; v.exp_in = i; v.exp_done = dn;
      v.exp_err = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Inputs are changed 1 time unit after a rising edge; outputs are
   // sampled 1 time unit after the following rising edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string nm, input logic b, input logic [31:0] o,
                        input logic [31:0] i, input logic dn, input logic er);
      chk({nm, ".busy"},   32'(ifb.busy),   32'(b));
      chk({nm, ".out_en"}, 32'(ifb.out_en), o);
      chk({nm, ".in_en"},  32'(ifb.in_en),  i);
      chk({nm, ".done"},   32'(ifb.done),   32'(dn));
      chk({nm, ".err"},    32'(ifb.err),    32'(er));
   endtask

   localparam logic [31:0] B_CNT_MAX = 32'd3;   // 2**CNT_W-1 for DUT B
   logic [31:0] exp_cnt;

   task automatic b_xfer(input int s, input int d);
      logic [31:0] os, od;
      os = 32'd1 << s;
      od = 32'd1 << d;
      ifb.start = 1'b1; ifb.src_sel = 5'(s); ifb.dst_sel = 5'(d);
      step();
      chk_b("cnt_drive", 1'b1, os, 32'd0, 1'b0, 1'b0);
      ifb.start = 1'b0;
      step();
      chk_b("cnt_load", 1'b1, os, od, 1'b0, 1'b0);
      step();
`ifdef BUS_XFER_COUNT_EN
      if (exp_cnt != B_CNT_MAX) exp_cnt = exp_cnt + 32'd1;
`endif
      chk_b("cnt_done", 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("cnt_value_done", 32'(ifb.xfer_count), exp_cnt);
      step();
      chk_b("cnt_idle", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("cnt_value_idle", 32'(ifb.xfer_count), exp_cnt);
   endtask

   initial begin
      // Reset with start asserted
      vecs.push_back(mk("rst0",    0, 1,  3, 17, 0, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk("rst1",    0, 1,  3, 17, 0, 32'h0, 32'h0, 0, 0));
      // Basic transfer 3 -> 17
      vecs.push_back(mk("basic_d", 1, 1,  3, 17, 1, 32'h8, 32'h0, 0, 0));
      vecs.push_back(mk("basic_l", 1, 0,  3, 17, 1, 32'h8, 32'h0002_0000, 0, 0));
      vecs.push_back(mk("basic_x", 1, 0,  3, 17, 1, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk("basic_i", 1, 0,  3, 17, 0, 32'h0, 32'h0, 0, 0));
      // start held 8 cycles; src_sel wiggled mid-transfer
      vecs.push_back(mk("hold0",   1, 1,  0, 31, 1, 32'h1, 32'h0, 0, 0));
      vecs.push_back(mk("hold1",   1, 1,  5, 31, 1, 32'h1, 32'h8000_0000, 0, 0));
      vecs.push_back(mk("hold2",   1, 1,  5, 31, 1, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk("hold3",   1, 1,  0, 31, 0, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk("hold4",   1, 1,  0, 31, 1, 32'h1, 32'h0, 0, 0));
      vecs.push_back(mk("hold5",   1, 1,  7, 31, 1, 32'h1, 32'h8000_0000, 0, 0));
      vecs.push_back(mk("hold6",   1, 1,  7, 31, 1, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk("hold7",   1, 1,  0, 31, 0, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk("hold_end",1, 0,  0, 31, 0, 32'h0, 32'h0, 0, 0));
      // src == dst
      vecs.push_back(mk("same_d",  1, 1,  9,  9, 1, 32'h200, 32'h0, 0, 0));
      vecs.push_back(mk("same_l",  1, 0,  9,  9, 1, 32'h200, 32'h200, 0, 0));
      vecs.push_back(mk("same_x",  1, 0,  9,  9, 1, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk("same_i",  1, 0,  9,  9, 0, 32'h0, 32'h0, 0, 0));
      // Abort during LOAD; reset also wins over start
      vecs.push_back(mk("abrt_d",  1, 1,  2,  4, 1, 32'h4, 32'h0, 0, 0));
      vecs.push_back(mk("abrt_l",  1, 0,  2,  4, 1, 32'h4, 32'h10, 0, 0));
      vecs.push_back(mk("abrt_r",  0, 1,  2,  4, 0, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk("abrt_a1", 1, 0,  2,  4, 0, 32'h0, 32'h0, 0, 0));
      vecs.push_back(mk("abrt_a2", 1, 0,  2,  4, 0, 32'h0, 32'h0, 0, 0));
      // Back-to-back after the abort: highest index on both sides
      vecs.push_back(mk("top_d",   1, 1, 31, 31, 1, 32'h8000_0000, 32'h0, 0, 0));
      vecs.push_back(mk("top_l",   1, 0, 31, 31, 1, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(mk("top_x",   1, 0, 31, 31, 1, 32'h0, 32'h0, 1, 0));
      vecs.push_back(mk("top_i",   1, 0, 31, 31, 0, 32'h0, 32'h0, 0, 0));

      clear_n     = 1'b0;
      ifa.start   = 1'b0; ifa.src_sel = '0; ifa.dst_sel = '0;
      ifb.start   = 1'b0; ifb.src_sel = '0; ifb.dst_sel = '0;
      step();

      foreach (vecs[k]) begin
         clear_n     = vecs[k].rst_n;
         ifa.start   = vecs[k].start;
         ifa.src_sel = vecs[k].src;
         ifa.dst_sel = vecs[k].dst;
         step();
         chk({vecs[k].name, ".busy"},   32'(ifa.busy),   32'(vecs[k].exp_busy));
         chk({vecs[k].name, ".out_en"}, ifa.out_en,      vecs[k].exp_out);
         chk({vecs[k].name, ".in_en"},  ifa.in_en,       vecs[k].exp_in);
         chk({vecs[k].name, ".done"},   32'(ifa.done),   32'(vecs[k].exp_done));
         chk({vecs[k].name, ".err"},    32'(ifa.err),    32'(vecs[k].exp_err));
      end
      ifa.start = 1'b0;

      // DUT B: fresh reset, then range rejects
      clear_n = 1'b0;
      step();
      clear_n = 1'b1;
      chk_b("b_reset", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("b_reset_cnt", 32'(ifb.xfer_count), 32'd0);

      ifb.start = 1'b1; ifb.src_sel = 5'd25; ifb.dst_sel = 5'd3;
      step();
      chk_b("rng_src25", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      ifb.start = 1'b0;
      step();
      chk_b("rng_src25_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      step();
      chk_b("rng_src25_nodone", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

      ifb.start = 1'b1; ifb.src_sel = 5'd0; ifb.dst_sel = 5'd24;
      step();
      chk_b("rng_dst24", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      ifb.start = 1'b0;
      step();
      chk_b("rng_dst24_after", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

      // Counter: 5 valid transfers with a rejected request in between
      exp_cnt = 32'd0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            ifb.start = 1'b1; ifb.src_sel = 5'd30; ifb.dst_sel = 5'd1;
            step();
            chk_b("cnt_err", 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("cnt_err_value", 32'(ifb.xfer_count), exp_cnt);
            ifb.start = 1'b0;
            step();
         end
         b_xfer(k, 23 - k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
